// File: rtl/store_narrow_rmw_pkg.sv
// Shared definitions for the store narrowing unit: access size codes,
// FSM state encoding and the alignment rule used at request acceptance.
package store_narrow_rmw_pkg;

    // Access size codes, shared with the load extender.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_MRG  = 3'd2,
        ST_WR   = 3'd3,
        ST_ERR  = 3'd4
    } state_e;

    // A request is legal when its size is defined and its byte address
    // is naturally aligned for that size.
    function automatic logic is_legal(input logic [1:0] size, input logic [1:0] lo);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = (lo[0] == 1'b0);
            SZ_WORD: ok = (lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/store_narrow_rmw_if.sv
// Store request channel plus word-only data memory port.
// The slave modport is the narrowing unit; the master side is the
// MEM stage / data memory.
interface store_narrow_rmw_if #(
    parameter int WADDR_W = 10
);
    import store_narrow_rmw_pkg::*;

    logic               st_valid;
    logic               st_ready;
    logic [31:0]        st_addr;
    logic [31:0]        st_data;
    logic [1:0]         st_size;
    logic               st_done;
    logic               st_err;
    logic [WADDR_W-1:0] mem_addr;
    logic               mem_rden;
    logic [31:0]        mem_rddata;
    logic               mem_wren;
    logic [31:0]        mem_wrdata;

    modport slave (
        input  st_valid, st_addr, st_data, st_size, mem_rddata,
        output st_ready, st_done, st_err, mem_addr, mem_rden, mem_wren, mem_wrdata
    );

    modport master (
        output st_valid, st_addr, st_data, st_size, mem_rddata,
        input  st_ready, st_done, st_err, mem_addr, mem_rden, mem_wren, mem_wrdata
    );

endinterface

// File: rtl/store_narrow_rmw_lane_merge.sv
// Combinational lane merge: replaces the addressed byte or halfword of
// an existing word with the low bits of the new data (little-endian).
// A word-size merge simply passes the new data through.
module store_narrow_rmw_lane_merge
    import store_narrow_rmw_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    output logic [31:0] merged
);

    // Overlay the selected lane onto the old word; other bits are kept.
    always_comb begin
        merged = old_word;
        case (size)
            SZ_BYTE: begin
                case (lane)
                    2'd0:    merged[7:0]   = new_data[7:0];
                    2'd1:    merged[15:8]  = new_data[7:0];
                    2'd2:    merged[23:16] = new_data[7:0];
                    2'd3:    merged[31:24] = new_data[7:0];
                    default: merged        = old_word;
                endcase
            end
            SZ_HALF: begin
                if (lane[1]) begin
                    merged[31:16] = new_data[15:0];
                end else begin
                    merged[15:0]  = new_data[15:0];
                end
            end
            SZ_WORD: merged = new_data;
            default: merged = old_word;
        endcase
    end

endmodule

// File: rtl/store_narrow_rmw.sv
// Store narrowing unit: accepts SW/SH/SB from the MEM stage and performs
// a read-modify-write on word-only data memory for sub-word stores.
// Every output is a flop loaded from the next state, so nothing reaches
// the memory or the pipeline combinationally from the request inputs.
module store_narrow_rmw
    import store_narrow_rmw_pkg::*;
#(
    parameter int WADDR_W = 10
) (
    input  logic                clk,
    input  logic                reset,
    store_narrow_rmw_if.slave   bus
);

    state_e             state_r;
    state_e             next_s;
    logic               accept_s;
    logic [31:0]        data_r;
    logic [1:0]         size_r;
    logic [1:0]         lane_r;
    logic [31:0]        m_data_s;
    logic [1:0]         m_size_s;
    logic [1:0]         m_lane_s;
    logic [31:0]        merged_s;
    logic               st_ready_r;
    logic               st_done_r;
    logic               st_err_r;
    logic               mem_rden_r;
    logic               mem_wren_r;
    logic [WADDR_W-1:0] mem_addr_r;
    logic [31:0]        mem_wrdata_r;
    logic               unused_addr_s;

    // Address bits above the memory size wrap and are deliberately dropped.
    assign unused_addr_s = ^bus.st_addr[31:WADDR_W+2];

    // Next-state decode; a request is only looked at while idle.
    always_comb begin
        next_s   = state_r;
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.st_valid) begin
                    accept_s = 1'b1;
                    if (!is_legal(bus.st_size, bus.st_addr[1:0])) begin
                        next_s = ST_ERR;
                    end else if (bus.st_size == SZ_WORD) begin
                        next_s = ST_WR;
                    end else begin
                        next_s = ST_RD;
                    end
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_RD:   next_s = ST_MRG;
            ST_MRG:  next_s = ST_WR;
            ST_WR:   next_s = ST_IDLE;
            ST_ERR:  next_s = ST_IDLE;
            default: next_s = ST_IDLE;
        endcase
    end

    // Merge operands: live request for a full word written straight from
    // IDLE, latched request for a sub-word write after the read.
    always_comb begin
        if (state_r == ST_IDLE) begin
            m_data_s = bus.st_data;
            m_size_s = bus.st_size;
            m_lane_s = bus.st_addr[1:0];
        end else begin
            m_data_s = data_r;
            m_size_s = size_r;
            m_lane_s = lane_r;
        end
    end

    store_narrow_rmw_lane_merge u_lane_merge (
        .old_word (bus.mem_rddata),
        .new_data (m_data_s),
        .size     (m_size_s),
        .lane     (m_lane_s),
        .merged   (merged_s)
    );

    // State, request latch and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            data_r       <= 32'h0000_0000;
            size_r       <= 2'b00;
            lane_r       <= 2'b00;
            st_ready_r   <= 1'b1;
            st_done_r    <= 1'b0;
            st_err_r     <= 1'b0;
            mem_rden_r   <= 1'b0;
            mem_wren_r   <= 1'b0;
            mem_addr_r   <= '0;
            mem_wrdata_r <= 32'h0000_0000;
        end else begin
            state_r    <= next_s;
            st_ready_r <= (next_s == ST_IDLE);
            st_done_r  <= (next_s == ST_WR);
            st_err_r   <= (next_s == ST_ERR);
            mem_rden_r <= (next_s == ST_RD);
            mem_wren_r <= (next_s == ST_WR);
            if (accept_s) begin
                data_r <= bus.st_data;
                size_r <= bus.st_size;
                lane_r <= bus.st_addr[1:0];
            end
            // Address only moves for a legal access; it then holds through MRG.
            if (accept_s && (next_s != ST_ERR)) begin
                mem_addr_r <= bus.st_addr[WADDR_W+1:2];
            end
            if (next_s == ST_WR) begin
                mem_wrdata_r <= merged_s;
            end
        end
    end

    assign bus.st_ready   = st_ready_r;
    assign bus.st_done    = st_done_r;
    assign bus.st_err     = st_err_r;
    assign bus.mem_rden   = mem_rden_r;
    assign bus.mem_wren   = mem_wren_r;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_wrdata = mem_wrdata_r;

endmodule

// File: tb/tb_store_narrow_rmw.sv
// Bench for store_narrow_rmw: directed spec scenarios followed by random
// stores, checked against a word-array memory model updated by byte/half
// masking arithmetic.
module tb_store_narrow_rmw;

    localparam int WADDR_W = 10;
    localparam int NWORDS  = 1024;

    logic clk = 1'b0;
    logic reset;
    logic preload;
    logic [31:0] mem [0:NWORDS-1];
    logic [31:0] ref_mem [0:NWORDS-1];
    logic [31:0] last_wdata;
    logic [31:0] last_maddr;
    int n_cmp = 0;
    int n_err = 0;

    store_narrow_rmw_if #(.WADDR_W(WADDR_W)) bus ();

    store_narrow_rmw #(.WADDR_W(WADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int i);
        return 32'h3C5A_0000 ^ (i * 32'h0101_0307);
    endfunction

    // Data memory: word writes, 1-cycle read latency, junk when not read.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < NWORDS; i++) mem[i] <= pat(i);
        end else if (bus.mem_wren) begin
            mem[bus.mem_addr] <= bus.mem_wrdata;
        end
        if (bus.mem_rden) bus.mem_rddata <= mem[bus.mem_addr];
        else              bus.mem_rddata <= $urandom;
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
            $error("check %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] status();
        return {27'd0, bus.st_ready, bus.mem_rden, bus.mem_wren, bus.st_done, bus.st_err};
    endfunction

    // Present a request and return just after its acceptance edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                         output int waited);
        bus.st_addr  = a;
        bus.st_data  = d;
        bus.st_size  = s;
        bus.st_valid = 1'b1;
        waited = 0;
        while (bus.st_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) check32("accept_timeout", {31'd0, bus.st_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.st_valid = 1'b0;
        bus.st_addr  = $urandom;
        bus.st_data  = $urandom;
        bus.st_size  = 2'($urandom_range(0, 3));
    endtask

    // Check the cycle-by-cycle response to an accepted request.
    task automatic check_txn(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                             output logic [31:0] wr_obs);
        int unsigned wa, k, sh;
        logic legal;
        logic [31:0] expw, mask, exp_st, exp_addr;
        int ncyc, wcyc;
        wa    = (a / 4) % NWORDS;
        k     = a % 4;
        legal = (s == 2'd0) || (s == 2'd1 && (a % 2) == 0) || (s == 2'd2 && k == 0);
        if (s == 2'd0) begin
            sh = 8 * k;
            mask = 32'h0000_00FF << sh;
            expw = (ref_mem[wa] & ~mask) | ((d & 32'h0000_00FF) << sh);
        end else if (s == 2'd1) begin
            sh = 16 * ((a / 2) % 2);
            mask = 32'h0000_FFFF << sh;
            expw = (ref_mem[wa] & ~mask) | ((d & 32'h0000_FFFF) << sh);
        end else begin
            expw = d;
        end
        ncyc     = (!legal || s == 2'd2) ? 2 : 4;
        wcyc     = legal ? ncyc - 1 : 0;
        exp_addr = legal ? wa : last_maddr;
        wr_obs   = last_wdata;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (c == ncyc)             exp_st = 32'h10;
            else if (!legal)           exp_st = 32'h01;
            else if (c == wcyc)        exp_st = 32'h06;
            else if (c == 1)           exp_st = 32'h08;
            else                       exp_st = 32'h00;
            check32($sformatf("status_c%0d", c), status(), exp_st);
            check32($sformatf("mem_addr_c%0d", c), {22'd0, bus.mem_addr}, exp_addr);
            if (c == wcyc) begin
                check32("mem_wrdata", bus.mem_wrdata, expw);
                wr_obs = bus.mem_wrdata;
                last_wdata = expw;
            end else begin
                check32($sformatf("wrdata_hold_c%0d", c), bus.mem_wrdata, last_wdata);
            end
        end
        if (legal) begin
            ref_mem[wa] = expw;
            last_maddr  = wa;
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                         output logic [31:0] wr_obs);
        int w;
        issue(a, d, s, w);
        check_txn(a, d, s, wr_obs);
    endtask

    initial begin
        logic [31:0] wr, a, d, a2, d2;
        logic [1:0] s;
        int w;

        for (int i = 0; i < NWORDS; i++) ref_mem[i] = pat(i);
        last_wdata = 32'h0;
        last_maddr = 32'h0;
        bus.st_valid = 1'b0;
        bus.st_addr  = 32'h0;
        bus.st_data  = 32'h0;
        bus.st_size  = 2'b00;
        reset   = 1'b0;
        preload = 1'b1;

        // Reset held for two cycles.
        repeat (2) @(posedge clk);
        #1;
        preload = 1'b0;
        @(negedge clk);
        check32("reset_status", status(), 32'h10);
        check32("reset_addr", {22'd0, bus.mem_addr}, 32'h0);
        check32("reset_wrdata", bus.mem_wrdata, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check32("idle_status", status(), 32'h10);

        // SW to 0x10.
        store(32'h0000_0010, 32'hDEAD_BEEF, 2'b10, wr);
        check32("sw_value", wr, 32'hDEAD_BEEF);

        // SB lane sweep and SH on word 4 = 0x11223344.
        store(32'h0000_0010, 32'h1122_3344, 2'b10, wr);
        store(32'h0000_0010, 32'hFFFF_FFAB, 2'b00, wr);
        check32("sb_lane0", wr, 32'h1122_33AB);
        store(32'h0000_0010, 32'h1122_3344, 2'b10, wr);
        store(32'h0000_0013, 32'hFFFF_FFAB, 2'b00, wr);
        check32("sb_lane3", wr, 32'hAB22_3344);
        store(32'h0000_0010, 32'h1122_3344, 2'b10, wr);
        store(32'h0000_0012, 32'h0000_CAFE, 2'b01, wr);
        check32("sh_upper", wr, 32'hCAFE_3344);

        // Misaligned and reserved requests.
        store(32'h0000_0011, 32'h1234_5678, 2'b01, wr);
        store(32'h0000_0012, 32'h1234_5678, 2'b10, wr);
        store(32'h0000_0020, 32'h1234_5678, 2'b11, wr);

        // Valid held while busy: next request waits for IDLE, data unaffected.
        a = 32'h0000_0015; d = $urandom;
        a2 = 32'h0000_0018; d2 = $urandom;
        issue(a, d, 2'b00, w);
        bus.st_addr = a2; bus.st_data = d2; bus.st_size = 2'b01; bus.st_valid = 1'b1;
        check_txn(a, d, 2'b00, wr);
        issue(a2, d2, 2'b01, w);
        check32("busy_accept_wait", w, 32'd0);
        check_txn(a2, d2, 2'b01, wr);

        // Reset during MRG aborts the store.
        issue(32'h0000_001C, 32'h0000_0077, 2'b00, w);
        @(negedge clk);
        check32("abort_rd", status(), 32'h08);
        @(negedge clk);
        check32("abort_mrg", status(), 32'h00);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check32("abort_idle", status(), 32'h10);
        check32("abort_addr", {22'd0, bus.mem_addr}, 32'h0);
        check32("abort_wrdata", bus.mem_wrdata, 32'h0);
        last_wdata = 32'h0;
        last_maddr = 32'h0;
        @(negedge clk);
        check32("abort_no_write", status(), 32'h10);
        check32("abort_mem", mem[7], ref_mem[7]);

        // Random stores, upper address bits random to exercise wrap.
        for (int n = 0; n < 80; n++) begin
            a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 7)) << 2) |
                32'($urandom_range(0, 3));
            d = $urandom;
            s = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            store(a, d, s, wr);
        end

        @(negedge clk);
        for (int i = 0; i < 8; i++) check32($sformatf("mem_word%0d", i), mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
